// File: rtl/mp_pkg.sv
// Shared definitions for the multi-precision datapath.
//   N     : operand width (result path is N+1 bits)
//   NCH   : number of limbs the adder walks through, one per cycle
//   CW    : limb width; NCH*CW covers the full N+1 result exactly
//   state_e : mod_addsub controller states
//   op_e    : modular operation select
package mp_pkg;
  localparam int N   = 1027;
  localparam int RW  = N + 1;
  localparam int NCH = 4;
  localparam int CW  = RW / NCH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD1  = 3'd1,
    WAIT1 = 3'd2,
    ADD2  = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_e;
endpackage

// File: rtl/mpadder.sv
// Limb-serial (N+1)-bit adder/subtractor.
//   clk, resetn : clock, async active-low reset
//   start       : load operands (ignored while an operation is running)
//   subtract    : 0 -> a+b, 1 -> a-b (mod 2^(N+1))
//   in_a, in_b  : N-bit unsigned operands, zero-extended to N+1 bits
//   result      : N+1-bit sum/difference, valid while done is high
//   done        : one-cycle pulse NCH+1 cycles after start is presented
module mpadder
  import mp_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N:0]   result,
  output logic         done
);
  localparam int CNTW = $clog2(NCH);

  logic [RW-1:0]   opa, opb;
  logic            carry, run;
  logic [CNTW-1:0] cnt;
  logic [CW:0]     csum;

  // Lowest limb of the shifting operands plus the carry from the previous limb.
  assign csum = {1'b0, opa[CW-1:0]} + {1'b0, opb[CW-1:0]} + {{CW{1'b0}}, carry};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      run    <= 1'b0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !run) begin
        // Subtraction as a + ~b + 1: invert b and seed the carry.
        opa   <= {1'b0, in_a};
        opb   <= subtract ? ~{1'b0, in_b} : {1'b0, in_b};
        carry <= subtract;
        cnt   <= '0;
        run   <= 1'b1;
      end else if (run) begin
        // Limbs enter result from the top; after NCH shifts it is aligned.
        result <= {csum[CW-1:0], result[RW-1:CW]};
        opa    <= opa >> CW;
        opb    <= opb >> CW;
        carry  <= csum[CW];
        cnt    <= cnt + 1'b1;
        if (cnt == CNTW'(NCH - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/mod_addsub.sv
// Modular add/subtract controller: (a+b) mod M or (a-b) mod M using two
// back-to-back operations on a single mpadder (raw op, then correction by M).
// The correction always runs so latency does not depend on the data.
//   clk, resetn : clock, async active-low reset (shared with the adder)
//   start       : request, sampled only in IDLE
//   subtract    : 0 -> add, 1 -> subtract; latched with start
//   in_a, in_b  : operands, expected < M
//   in_m        : modulus, expected 0 < M < 2^(N-1)
//   result      : modular result, updated with done, held until next completion
//   done        : one-cycle completion pulse
//   busy        : high while an operation is in flight
module mod_addsub
  import mp_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy
);
  state_e       state, state_nxt;
  op_e          op_q;
  logic [N-1:0] a_q, b_q, m_q, r_q;
  logic         s_q;

  logic         add_start, add_sub, add_done;
  logic [N-1:0] add_a, add_b, final_val;
  logic [N:0]   add_res;

  mpadder u_add (
    .clk      (clk),
    .resetn   (resetn),
    .start    (add_start),
    .subtract (add_sub),
    .in_a     (add_a),
    .in_b     (add_b),
    .result   (add_res),
    .done     (add_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    add_start = 1'b0;
    add_a     = a_q;
    add_b     = b_q;
    add_sub   = (op_q == SUB);
    case (state)
      IDLE:  if (start) state_nxt = ADD1;
      ADD1: begin
        add_start = 1'b1;
        state_nxt = WAIT1;
      end
      WAIT1: if (add_done) state_nxt = ADD2;
      ADD2: begin
        // Correction: add path tries r-M, sub path prepares r+M.
        add_start = 1'b1;
        add_a     = r_q;
        add_b     = m_q;
        add_sub   = (op_q == ADD);
        state_nxt = WAIT2;
      end
      WAIT2: if (add_done) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Add: keep r when r-M went negative. Sub: wrap by M when a<b.
  always_comb begin
    final_val = r_q;
    if (op_q == ADD) final_val = add_res[N] ? r_q : add_res[N-1:0];
    else             final_val = s_q ? add_res[N-1:0] : r_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      op_q   <= ADD;
      r_q    <= '0;
      s_q    <= 1'b0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        a_q  <= in_a;
        b_q  <= in_b;
        m_q  <= in_m;
        op_q <= op_e'(subtract);
      end
      if (state == WAIT1 && add_done) begin
        r_q <= add_res[N-1:0];
        s_q <= add_res[N];
      end
      if (state == WAIT2 && add_done) begin
        result <= final_val;
        done   <= 1'b1;
      end
    end
  end
endmodule
